// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared state encodings and constants for the binary-to-BCD converter
//
// Purpose : State type, nibble-adjust constants and time-field bound used by
//           bin2bcd_seq and its per-nibble adjust cell.
// Ports   : none (package).
`timescale 1ns/1ps

package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Double-dabble nibble correction: a digit of 5 or more would overflow
  // past 9 after the next doubling, so it is pre-biased by 3.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Largest legal minutes/seconds value.
  localparam int TIME_FIELD_MAX = 59;

  // Largest value representable in the given number of decimal digits.
  function automatic int pow10_minus1(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_adj3.sv
// rtl/bin2bcd_seq_bcd_adj3.sv - combinational add-3-if-at-least-5 correction for one BCD nibble
//
// Purpose : One double-dabble correction cell; the top instantiates one per
//           BCD digit. Pure 4-bit arithmetic, no carry into the next nibble.
// Ports   : nib_in  [3:0] BCD digit before correction
//           nib_out [3:0] digit after the conditional +3
`timescale 1ns/1ps

module bin2bcd_seq_bcd_adj3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // The largest input that gets adjusted is a valid digit (<=9 in a legal
  // conversion), so 9+3=12 still fits in four bits.
  assign nib_out = (nib_in >= BCD_ADJ_THRESH) ? (nib_in + BCD_ADJ_ADD) : nib_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake
//
// Purpose : Converts an IN_W-bit binary field value (minutes/seconds/hours) to
//           DIGITS packed BCD digits, one bit per clock, so a single instance
//           can be time-shared across fields by the controller FSM.
// Build option : define TIME_FIELD_CHECK_EN to bound the range check at 59 and
//           force bcd_out to zero on an out-of-range value. Without it the
//           bound is 10^DIGITS-1 and the low digits are passed through.
// Ports   : clk      rising-edge clock
//           reset    asynchronous active-low reset (0 = reset)
//           start    conversion request, sampled only when idle
//           bin_in   [IN_W-1:0] binary value, captured on the accepting cycle
//           busy     high from the cycle after start up to the result cycle
//           done     one-cycle pulse, bcd_out/err valid
//           bcd_out  [4*DIGITS-1:0] packed BCD, MS digit in the top nibble, held
//           err      range error of the last conversion, held
`timescale 1ns/1ps

module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = 2
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

`ifdef TIME_FIELD_CHECK_EN
  localparam int ERR_LIMIT = TIME_FIELD_MAX;
`else
  localparam int ERR_LIMIT = pow10_minus1(DIGITS);
`endif

  state_t            state;
  logic [SR_W-1:0]   sreg;      // {BCD digits, remaining binary bits}
  logic [CNT_W-1:0]  count;
  logic              err_pend;  // range result of the value being converted

  logic [BCD_W-1:0]  bcd_adj;
  logic [SR_W-1:0]   sreg_adj;
  logic              in_range_err;
  logic [BCD_W-1:0]  bcd_result;

  // Per-digit correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_seq_bcd_adj3 u_adj (
      .nib_in  (sreg[IN_W + 4*g +: 4]),
      .nib_out (bcd_adj[4*g +: 4])
    );
  end

  assign sreg_adj = {bcd_adj, sreg[IN_W-1:0]};

  // Range is decided on the raw input at capture time; the binary bits are
  // shifted out during conversion so they cannot be compared later.
  assign in_range_err = ({{(32-IN_W){1'b0}}, bin_in} > 32'(ERR_LIMIT));

  // Digits above DIGITS are shifted out of the top, which leaves the low
  // decimal digits of an oversize value intact (127 -> 27).
`ifdef TIME_FIELD_CHECK_EN
  assign bcd_result = err_pend ? '0 : sreg[SR_W-1 -: BCD_W];
`else
  assign bcd_result = sreg[SR_W-1 -: BCD_W];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      count    <= '0;
      err_pend <= 1'b0;
      bcd_out  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sreg     <= {{BCD_W{1'b0}}, bin_in};
            count    <= '0;
            err_pend <= in_range_err;
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          sreg  <= {sreg_adj[SR_W-2:0], 1'b0};
          count <= count + 1'b1;
          if (count == LAST_CNT) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          bcd_out <= bcd_result;
          err     <= err_pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Receives the 7-bit binary field value produced by the minutes/seconds/hours data counters.
- Emits packed BCD tens/units digits for the RTC write path and the 7-segment/VGA display.
- Start/busy/done handshake lets one instance be time-shared across fields by the controller FSM.

Parameters:
- IN_W, 7, width of binary input; legal range 4..7.
- DIGITS, 2, number of BCD output digits; output width 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  IN_W  binary value; captured on the start cycle only.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result valid.
- bcd_out  output  4*DIGITS  packed BCD, MS digit in top nibble; registered and held.
- err  output  1  range error flag for the last conversion; registered and held.

Behaviour:
- Reset asserted (reset=0), at any time including mid-conversion:
  - state=IDLE, bcd_out=0, err=0, busy=0, done=0.
  - Internal shift register and counter cleared.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads the shift register as {zeros(4*DIGITS), bin_in} and sets count=0.
  - Next state is SHIFT. start=0 stays in IDLE.
- SHIFT, one bit per cycle, in this order:
  - Any BCD nibble >=5 gets +3 (4-bit add, no carry between nibbles).
  - Whole register shifts left by 1.
  - count increments. When count reaches IN_W-1 on this shift, next state is DONE.
- DONE, one cycle:
  - bcd_out <= BCD nibbles; err <= range result; done=1.
  - Next state is IDLE.
- Latency: start sampled at edge N → done=1 and new bcd_out during cycle N+IN_W+1 (N+8 by default).
  - Back-to-back start in the cycle after done is legal; throughput is IN_W+2 cycles.
- start while busy=1 is ignored, not queued. bin_in changes after capture have no effect.
- busy=1 from the cycle after start through the DONE cycle inclusive.
- Range check (default build): err=1 when bin_in > 10^DIGITS-1, i.e. >99 for 2 digits.
  - When err=1, bcd_out holds the low DIGITS digits: 127 → 0x27, err=1.
- bcd_out and err change only in DONE or on reset.

Optional Feature:
- Macro TIME_FIELD_CHECK_EN.
- Defined:
  - Error bound becomes 59, so err=1 for bin_in>59.
  - On error, bcd_out is forced to 0x00, so the tens digit presented to the RTC is always 0..5.
- Undefined: range check as in Behaviour (bound 10^DIGITS-1, low digits passed through).

Decomposition:
- Shared package/header: state encodings ST_IDLE/ST_SHIFT/ST_DONE, BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3, TIME_FIELD_MAX=59.
- One natural sub-module: bcd_adj3 (combinational per-nibble add-3-if-≥5), instantiated DIGITS times.
- Shift, counter and FSM stay in the top module.

Test Plan:
- Reset low mid-conversion (3 cycles after start with bin_in=45), then release → bcd_out=0x00, err=0, busy=0; next start bin_in=45 converts normally.
- bin_in=59, start pulse → done exactly 8 cycles after start edge; bcd_out=0x59, err=0; busy high 8 cycles.
- Sweep bin_in=0..99 back-to-back, start in cycle after each done → every bcd_out matches decimal reference; err=0 throughout.
- bin_in=127 → default build: bcd_out=0x27, err=1; with TIME_FIELD_CHECK_EN: bcd_out=0x00, err=1. bin_in=60 with macro → err=1, bcd_out=0x00.
- start held high continuously with bin_in toggling 12↔34 → results alternate at throughput IN_W+2; busy-time starts ignored; each result equals value at the accepting cycle.
- bin_in=0 and bin_in=9 → bcd_out=0x00 and 0x09 (no spurious adjust); done pulses are exactly one cycle wide.
